// File: rtl/uart_pkg.sv
// Shared constants for the APB UART: register map, STATUS/CTRL bit positions,
// FSM state encodings and the BAUD floor.
package uart_pkg;

  localparam logic [3:0] OffData   = 4'h0;
  localparam logic [3:0] OffStatus = 4'h4;
  localparam logic [3:0] OffCtrl   = 4'h8;
  localparam logic [3:0] OffBaud   = 4'hC;

  localparam int unsigned StatRxNotEmpty = 0;
  localparam int unsigned StatRxFull     = 1;
  localparam int unsigned StatTxEmpty    = 2;
  localparam int unsigned StatTxFull     = 3;
  localparam int unsigned StatTxBusy     = 4;
  localparam int unsigned StatOverrun    = 5;
  localparam int unsigned StatFrameErr   = 6;

  localparam int unsigned CtrlTxEn  = 0;
  localparam int unsigned CtrlRxEn  = 1;
  localparam int unsigned CtrlIeRx  = 2;
  localparam int unsigned CtrlIeTx  = 3;
  localparam int unsigned CtrlIeErr = 4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  localparam logic [15:0] BaudMin = 16'd4;

  function automatic logic [15:0] clamp_baud(input logic [15:0] val);
    return (val < BaudMin) ? BaudMin : val;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO succeeds when a pop happens in
// the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCount);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB slave UART (8N1) with TX/RX FIFOs, sticky error flags and a level IRQ.
// APB decode and both serial engines live here; storage is in uart_sync_fifo.
module apb_uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLK_FREQ_MHZ = 125,
  parameter int unsigned BAUDRATE     = 9600
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  input  logic                  rx,
  output logic                  tx,
  output logic                  uart_irq
);

  localparam int unsigned ResetDivRaw = CLK_FREQ_MHZ * 1000000 / BAUDRATE;
  localparam logic [15:0] ResetDiv    = clamp_baud(ResetDivRaw[15:0]);

  logic        access, addr_ok, err, wr_ok, rd_ok, tx_push, rx_pop, sts_wr;
  logic [3:0]  offset;
  logic [6:0]  status;
  logic [4:0]  ctrl_q;
  logic [15:0] baud_q;
  logic        overrun_q, frame_err_q, irq_q;
  logic [7:0]  tx_rdata, rx_rdata;
  logic        tx_empty, tx_full, rx_empty, rx_full, tx_pop, rx_push, fe_set, ovr_set;
  logic        unused_pwdata;

  logic [1:0]  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_bit_end;

  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_bit_end;

  assign unused_pwdata = ^pwdata[31:16];

  // Registers sit in paddr[3:0]; any higher address bit set is an unmapped offset.
  assign access  = pselx & penable & ~prst;
  assign offset  = paddr[3:0];
  assign addr_ok = ((paddr >> 4) == '0) && (offset[1:0] == 2'b00);

  always_comb begin
    err = 1'b0;
    if (access) begin
      if (!addr_ok)                                   err = 1'b1;
      else if (offset == OffData && pwrite && tx_full)   err = 1'b1;
      else if (offset == OffData && !pwrite && rx_empty) err = 1'b1;
    end
  end

  assign wr_ok   = access & pwrite & ~err;
  assign rd_ok   = access & ~pwrite & ~err;
  assign tx_push = wr_ok & (offset == OffData);
  assign rx_pop  = rd_ok & (offset == OffData);
  assign sts_wr  = wr_ok & (offset == OffStatus);
  assign pready  = 1'b1;
  assign pslverr = err;
  assign status  = {frame_err_q, overrun_q, tx_state_q != StIdle, tx_full, tx_empty, rx_full,
                    ~rx_empty};

  always_comb begin
    prdata = '0;
    if (rd_ok) begin
      case (offset)
        OffData:   prdata[7:0]  = rx_rdata;
        OffStatus: prdata[6:0]  = status;
        OffCtrl:   prdata[4:0]  = ctrl_q;
        OffBaud:   prdata[15:0] = baud_q;
        default:   prdata       = '0;
      endcase
    end
  end

  assign ovr_set = rx_push & rx_full & ~rx_pop;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      ctrl_q      <= '0;
      baud_q      <= ResetDiv;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (wr_ok && offset == OffCtrl) ctrl_q <= pwdata[4:0];
      if (wr_ok && offset == OffBaud) baud_q <= clamp_baud(pwdata[15:0]);
      overrun_q   <= ovr_set | (overrun_q & ~(sts_wr & pwdata[StatOverrun]));
      frame_err_q <= fe_set | (frame_err_q & ~(sts_wr & pwdata[StatFrameErr]));
      irq_q       <= (ctrl_q[CtrlIeRx] & ~rx_empty) | (ctrl_q[CtrlIeTx] & tx_empty) |
                     (ctrl_q[CtrlIeErr] & (overrun_q | frame_err_q));
    end
  end

  assign uart_irq = irq_q;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(pclk), .rst_i(prst), .push_i(tx_push), .wdata_i(pwdata[7:0]), .pop_i(tx_pop),
    .rdata_o(tx_rdata), .empty_o(tx_empty), .full_o(tx_full)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(pclk), .rst_i(prst), .push_i(rx_push), .wdata_i(rx_shift_d), .pop_i(rx_pop),
    .rdata_o(rx_rdata), .empty_o(rx_empty), .full_o(rx_full)
  );

  // TX engine: tx_q is registered so the line never glitches on state decode.
  assign tx_pop     = (tx_state_q == StIdle) & ctrl_q[CtrlTxEn] & ~tx_empty;
  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (tx_pop) begin
          tx_state_d = StStart;
          tx_div_d   = baud_q;
          tx_shift_d = tx_rdata;
          tx_d       = 1'b0;
        end
      end
      StStart: if (tx_bit_end) begin
        tx_state_d = StData;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
      end
      StData: if (tx_bit_end) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = StStop;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      default: if (tx_bit_end) begin
        tx_state_d = StIdle;
        tx_cnt_d   = '0;
      end
    endcase
  end

  // RX engine: samples the synchronised line mid-bit, timing from the start edge.
  assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (ctrl_q[CtrlRxEn] && rx_prev_q && !rx_s2_q) begin
          rx_state_d = StStart;
          rx_div_d   = baud_q;
        end
      end
      StStart: if (rx_cnt_q == (rx_div_q >> 1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? StIdle : StData;
      end
      StData: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = StStop;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      default: if (rx_bit_end) begin
        rx_state_d = StIdle;
        rx_push    = rx_s2_q;
        fe_set     = ~rx_s2_q;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= ResetDiv;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= ResetDiv;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

  assign tx = tx_q;

endmodule
